// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// Sequences data-memory loads and stores for the single-cycle core over a
// req/ready + rvalid handshake. The core is stalled while an access is
// outstanding. Load data is lane-steered and extended, and then written back
// once to the register file.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   isLoad, isStore         current instruction is a load / store
//   addr, storeData         effective address, store source value
//   size, loadUnsigned      0=byte 1=half 2=word 3=illegal; zero/sign extend
//   rdIn                    load destination register
//   mem_req/we/addr/wdata/wstrb   registered memory request
//   mem_ready, mem_rvalid, mem_rdata  memory responses
//   stall                   hold PC/instruction (combinational)
//   rdWrite, rd, wbData     one-cycle register-file write-back
//   misaligned, busError    one-cycle error pulses
module mem_access_sequencer #(
  parameter int REG_BITS = 5,
  parameter int XLEN     = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                isLoad,
  input  logic                isStore,
  input  logic [XLEN-1:0]     addr,
  input  logic [XLEN-1:0]     storeData,
  input  logic [1:0]          size,
  input  logic                loadUnsigned,
  input  logic [REG_BITS-1:0] rdIn,
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [3:0]          mem_wstrb,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                stall,
  output logic                rdWrite,
  output logic [REG_BITS-1:0] rd,
  output logic [XLEN-1:0]     wbData,
  output logic                misaligned,
  output logic                busError
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} stateType;

  stateType            state;
  stateType            stateNext;
  logic                isLoadQ;
  logic [1:0]          sizeQ;
  logic                unsignedQ;
  logic [1:0]          offsetQ;
  logic [REG_BITS-1:0] rdQ;
  logic [15:0]         timeoutCnt;

  logic                accessReq;
  logic                aligned;
  logic                timeoutHit;
  logic                issue;
  logic                rejectAccess;
  logic                accept;
  logic                capture;
  logic                abort;
  logic [XLEN-1:0]     wdataNext;
  logic [3:0]          wstrbNext;
  logic [XLEN-1:0]     loadValue;
  logic [7:0]          byteSel;
  logic [15:0]         halfSel;

  assign accessReq  = isLoad | isStore;
  assign timeoutHit = (timeoutCnt == 16'(TIMEOUT - 1));

  // Natural alignment check; size 3 never counts as aligned.
  always_comb begin
    aligned = 1'b0;
    case (size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~addr[0];
      2'd2:    aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Store lane steering: the datum is replicated across the word so the
  // memory picks the right lanes purely from the byte enables.
  always_comb begin
    wdataNext = storeData;
    wstrbNext = 4'b1111;
    case (size)
      2'd0: begin
        wdataNext = {4{storeData[7:0]}};
        wstrbNext = 4'b0001 << addr[1:0];
      end
      2'd1: begin
        wdataNext = {2{storeData[15:0]}};
        wstrbNext = 4'b0011 << addr[1:0];
      end
      default: begin
        wdataNext = storeData;
        wstrbNext = 4'b1111;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension using the attributes
  // latched when the access was issued.
  always_comb begin
    byteSel   = mem_rdata[{offsetQ, 3'b000} +: 8];
    halfSel   = mem_rdata[{offsetQ[1], 4'b0000} +: 16];
    loadValue = mem_rdata;
    case (sizeQ)
      2'd0:    loadValue = {{24{~unsignedQ & byteSel[7]}}, byteSel};
      2'd1:    loadValue = {{16{~unsignedQ & halfSel[15]}}, halfSel};
      default: loadValue = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state and control decode. A timeout takes priority over a
  // handshake arriving on the same cycle so the abort bound is exact.
  always_comb begin
    stateNext    = state;
    stall        = 1'b0;
    issue        = 1'b0;
    rejectAccess = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    abort        = 1'b0;
    case (state)
      IDLE: begin
        if (accessReq && aligned) begin
          stall     = 1'b1;
          issue     = 1'b1;
          stateNext = REQ;
        end else if (accessReq) begin
          rejectAccess = 1'b1;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (timeoutHit) begin
          abort     = 1'b1;
          stateNext = DONE;
        end else if (mem_ready) begin
          accept    = 1'b1;
          stateNext = isLoadQ ? WAIT : DONE;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (timeoutHit) begin
          abort     = 1'b1;
          stateNext = DONE;
        end else if (mem_rvalid) begin
          capture   = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Request registers, latched access attributes, timeout counter and
  // write-back/error outputs. rd and wbData change only when a load
  // actually completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      isLoadQ    <= 1'b0;
      sizeQ      <= '0;
      unsignedQ  <= 1'b0;
      offsetQ    <= '0;
      rdQ        <= '0;
      timeoutCnt <= '0;
      rd         <= '0;
      wbData     <= '0;
      rdWrite    <= 1'b0;
      misaligned <= 1'b0;
      busError   <= 1'b0;
    end else begin
      rdWrite    <= 1'b0;
      misaligned <= rejectAccess;
      busError   <= abort;
      if (issue) begin
        isLoadQ    <= isLoad;
        sizeQ      <= size;
        unsignedQ  <= loadUnsigned;
        offsetQ    <= addr[1:0];
        rdQ        <= rdIn;
        timeoutCnt <= '0;
        mem_req    <= 1'b1;
        mem_we     <= ~isLoad;
        mem_addr   <= {addr[XLEN-1:2], 2'b00};
        mem_wdata  <= isLoad ? '0 : wdataNext;
        mem_wstrb  <= isLoad ? 4'b0000 : wstrbNext;
      end else if (state == REQ || state == WAIT) begin
        timeoutCnt <= timeoutCnt + 16'd1;
      end
      if (accept || abort) begin
        mem_req <= 1'b0;
      end
      if (capture) begin
        wbData  <= loadValue;
        rd      <= rdQ;
        rdWrite <= (rdQ != '0);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer
// Self-checking bench for mem_access_sequencer. A main instance uses the
// default timeout; a second instance with TIMEOUT=4 shares the stimulus and
// is observed only for the bus-timeout scenario. Expected write-backs are
// queued when a load is driven and popped when rdWrite is seen.
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        isLoad, isStore, loadUnsigned;
  logic [31:0] addr, storeData, mem_rdata;
  logic [1:0]  size;
  logic [4:0]  rdIn;
  logic        mem_ready, mem_rvalid;

  logic        mem_req, mem_we, stall, rdWrite, misaligned, busError;
  logic [31:0] mem_addr, mem_wdata, wbData;
  logic [3:0]  mem_wstrb;
  logic [4:0]  rd;

  logic        memReqT, memWeT, stallT, rdWriteT, misalignedT, busErrorT;
  logic [31:0] memAddrT, memWdataT, wbDataT;
  logic [3:0]  memWstrbT;
  logic [4:0]  rdT;

  mem_access_sequencer dut (
    .clk(clk), .rst_n(rst_n), .isLoad(isLoad), .isStore(isStore),
    .addr(addr), .storeData(storeData), .size(size),
    .loadUnsigned(loadUnsigned), .rdIn(rdIn),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall(stall), .rdWrite(rdWrite), .rd(rd), .wbData(wbData),
    .misaligned(misaligned), .busError(busError)
  );

  mem_access_sequencer #(.TIMEOUT(4)) dutT (
    .clk(clk), .rst_n(rst_n), .isLoad(isLoad), .isStore(isStore),
    .addr(addr), .storeData(storeData), .size(size),
    .loadUnsigned(loadUnsigned), .rdIn(rdIn),
    .mem_req(memReqT), .mem_we(memWeT), .mem_addr(memAddrT),
    .mem_wdata(memWdataT), .mem_wstrb(memWstrbT),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall(stallT), .rdWrite(rdWriteT), .rd(rdT), .wbData(wbDataT),
    .misaligned(misalignedT), .busError(busErrorT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wbExpType;

  wbExpType    sbQueue[$];
  int          checks = 0;
  int          errors = 0;
  int          misCount = 0;
  int          busCountT = 0;
  int          rdWriteCountT = 0;
  int          stallCnt, reqCnt;
  logic [31:0] firstAddr, firstWdata;
  logic [3:0]  firstWstrb;
  logic        firstWe;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Error-pulse counters and the write-back scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    wbExpType e;
    if (rst_n) begin
      if (misaligned) misCount++;
      if (busErrorT)  busCountT++;
      if (rdWriteT)   rdWriteCountT++;
      if (rdWrite) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected rdWrite", 32'd1, 32'd0);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("wb rd", 32'(rd), 32'(e.rd));
          checkOutput("wb data", wbData, e.data);
        end
      end
    end
  end

  task automatic clearInputs();
    isLoad = 1'b0; isStore = 1'b0; addr = '0; storeData = '0; size = '0;
    loadUnsigned = 1'b0; rdIn = '0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    clearInputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one instruction and plays the memory side until the core is
  // released. readyLow: REQ cycles before ready; rvalidGap: cycles after
  // acceptance until rvalid (0 = never).
  task automatic applyStimulus(input logic ld, input logic st,
                               input logic [31:0] a, input logic [31:0] sd,
                               input logic [1:0] sz, input logic u,
                               input logic [4:0] r, input int readyLow,
                               input int rvalidGap, input logic [31:0] rdata,
                               input bit pushWb, input logic [31:0] expWb);
    int  acceptCyc;
    bit  accepted;
    bit  done;
    stallCnt = 0; reqCnt = 0; accepted = 0; done = 0; acceptCyc = 0;
    @(negedge clk);
    isLoad = ld; isStore = st; addr = a; storeData = sd; size = sz;
    loadUnsigned = u; rdIn = r; mem_rdata = rdata;
    if (pushWb) sbQueue.push_back('{r, expWb});
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (stall) stallCnt++;
      else       done = 1;
      if (mem_req) begin
        reqCnt++;
        if (reqCnt == 1) begin
          firstAddr = mem_addr; firstWdata = mem_wdata;
          firstWstrb = mem_wstrb; firstWe = mem_we;
        end else begin
          checkOutput("req addr stable", mem_addr, firstAddr);
          checkOutput("req wstrb stable", 32'(mem_wstrb), 32'(firstWstrb));
        end
        mem_ready = (reqCnt > readyLow);
        if (mem_ready) begin
          accepted = 1; acceptCyc = cyc;
        end
      end else begin
        mem_ready = 1'b0;
      end
      mem_rvalid = accepted && (rvalidGap > 0) && (cyc == acceptCyc + rvalidGap);
      @(negedge clk);
    end
    isLoad = 1'b0; isStore = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    if (!done) checkOutput("retire within budget", 32'd0, 32'd1);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    checkOutput("wb queue drained", 32'(sbQueue.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int misBefore, busBefore, stallCntT;
    bit releasedT;
    clearInputs();
    rst_n = 1'b0;
    #1;
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset stall", 32'(stall), 32'd0);
    checkOutput("reset rdWrite", 32'(rdWrite), 32'd0);
    checkOutput("reset wstrb", 32'(mem_wstrb), 32'd0);
    checkOutput("reset wbData", wbData, 32'd0);
    resetDut();

    $display("[TB] word load");
    applyStimulus(1, 0, 32'h100, 0, 2'd2, 0, 5'd5, 0, 2, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    checkOutput("word load stall cycles", 32'(stallCnt), 32'd4);
    checkOutput("word load addr", firstAddr, 32'h100);
    checkOutput("word load we", 32'(firstWe), 32'd0);
    settle();

    $display("[TB] byte loads");
    applyStimulus(1, 0, 32'h103, 0, 2'd0, 0, 5'd6, 0, 1, 32'h80FFFFFF, 1, 32'hFFFFFF80);
    checkOutput("byte load aligned addr", firstAddr, 32'h100);
    applyStimulus(1, 0, 32'h103, 0, 2'd0, 1, 5'd7, 0, 1, 32'h80FFFFFF, 1, 32'h00000080);
    applyStimulus(1, 0, 32'h102, 0, 2'd1, 0, 5'd8, 0, 1, 32'h80011234, 1, 32'hFFFF8001);
    settle();

    $display("[TB] stores");
    applyStimulus(0, 1, 32'h102, 32'h1234ABCD, 2'd1, 0, 5'd3, 0, 0, 0, 0, 0);
    checkOutput("half store wstrb", 32'(firstWstrb), 32'hC);
    checkOutput("half store wdata", firstWdata, 32'hABCDABCD);
    checkOutput("half store we", 32'(firstWe), 32'd1);
    checkOutput("half store stall cycles", 32'(stallCnt), 32'd2);
    applyStimulus(0, 1, 32'h101, 32'h0000005A, 2'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    checkOutput("byte store wstrb", 32'(firstWstrb), 32'h2);
    checkOutput("byte store wdata", firstWdata, 32'h5A5A5A5A);
    settle();
    checkOutput("wbData held after stores", wbData, 32'hFFFF8001);

    $display("[TB] misaligned");
    misBefore = misCount;
    applyStimulus(1, 0, 32'h101, 0, 2'd2, 0, 5'd4, 0, 1, 0, 0, 0);
    checkOutput("misaligned no req", 32'(reqCnt), 32'd0);
    checkOutput("misaligned no stall", 32'(stallCnt), 32'd0);
    settle();
    checkOutput("misaligned pulse", 32'(misCount - misBefore), 32'd1);
    misBefore = misCount;
    applyStimulus(1, 0, 32'h100, 0, 2'd3, 0, 5'd4, 0, 1, 0, 0, 0);
    checkOutput("size3 no req", 32'(reqCnt), 32'd0);
    settle();
    checkOutput("size3 pulse", 32'(misCount - misBefore), 32'd1);

    $display("[TB] slow ready, rd=0");
    applyStimulus(1, 0, 32'h300, 0, 2'd2, 0, 5'd0, 3, 1, 32'h55AA55AA, 0, 0);
    checkOutput("slow ready req cycles", 32'(reqCnt), 32'd4);
    checkOutput("slow ready stall cycles", 32'(stallCnt), 32'd6);
    settle();

    $display("[TB] load+store treated as load");
    applyStimulus(1, 1, 32'h40, 32'hFFFFFFFF, 2'd2, 0, 5'd12, 0, 1, 32'h11223344, 1, 32'h11223344);
    checkOutput("load+store we", 32'(firstWe), 32'd0);
    settle();

    $display("[TB] timeout");
    resetDut();
    busBefore = busCountT;
    misBefore = rdWriteCountT;
    stallCntT = 0;
    releasedT = 0;
    isLoad = 1'b1; addr = 32'h200; size = 2'd2; rdIn = 5'd9;
    for (int cyc = 0; cyc < 20 && !releasedT; cyc++) begin
      #1;
      if (stallT) stallCntT++;
      else        releasedT = 1;
      mem_ready = memReqT;
      @(negedge clk);
    end
    isLoad = 1'b0; mem_ready = 1'b0;
    if (!releasedT) checkOutput("timeout release", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("timeout stall cycles", 32'(stallCntT), 32'd5);
    checkOutput("busError pulse", 32'(busCountT - busBefore), 32'd1);
    checkOutput("timeout no rdWrite", 32'(rdWriteCountT - misBefore), 32'd0);
    checkOutput("timeout req dropped", 32'(memReqT), 32'd0);
    checkOutput("main dut still waiting", 32'(stall), 32'd1);

    $display("[TB] reset mid-wait");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset mid-wait mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset mid-wait stall", 32'(stall), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("after reset stall", 32'(stall), 32'd0);
    applyStimulus(1, 0, 32'h10, 0, 2'd2, 0, 5'd31, 0, 1, 32'hCAFEF00D, 1, 32'hCAFEF00D);
    checkOutput("post reset stall cycles", 32'(stallCnt), 32'd3);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Sequences data-memory loads and stores for the single-cycle CPU over a req/ready + rvalid memory handshake.
- Holds the core with a stall while an access is outstanding.
- Captures the destination register and access attributes.
- Performs byte-lane steering and load extension.
- Issues a single register-file write-back when load data returns.
- Sits between the core's execute stage and the data memory port, alongside the register-file write path.

Parameters:
REG_BITS, 5, width of register selector (rdIn/rd)
XLEN, 32, data/address width; only 32 supported
TIMEOUT, 255, max cycles spent in REQ+WAIT before abort (1..2^16-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
isLoad  in  1  current instruction is a load
isStore  in  1  current instruction is a store
addr  in  XLEN  effective address
storeData  in  XLEN  store source register value
size  in  2  0=byte, 1=half, 2=word, 3=illegal
loadUnsigned  in  1  zero-extend (1) / sign-extend (0) sub-word loads
rdIn  in  REG_BITS  load destination register
mem_req  out  1  access request (registered)
mem_we  out  1  1=store (registered)
mem_addr  out  XLEN  word-aligned address, addr[1:0] forced 0 (registered)
mem_wdata  out  XLEN  replicated store data (registered)
mem_wstrb  out  4  byte-enables (registered)
mem_ready  in  1  memory accepts request this cycle
mem_rvalid  in  1  load data valid
mem_rdata  in  XLEN  load data word
stall  out  1  hold PC/instruction (combinational)
rdWrite  out  1  register-file write enable, one cycle
rd  out  REG_BITS  write-back register
wbData  out  XLEN  extended load result
misaligned  out  1  one-cycle pulse: misaligned/illegal access, not issued
busError  out  1  one-cycle pulse: access timed out

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, rd, wbData, rdWrite, misaligned, busError and the timeout counter all go to 0.
  - An outstanding access is abandoned; mem_req drops immediately.
- Alignment: aligned = size==2 ? addr[1:0]==0 : size==1 ? addr[0]==0 : size==0. size 3 is illegal.
- IDLE:
  - If (isLoad|isStore) && aligned: latch rdIn, size, loadUnsigned, addr[1:0]; drive mem_* registers; go to REQ.
  - Store lanes: mem_wstrb = 0001<<off for byte, 0011<<off for half, 1111 for word. mem_wdata = byte replicated x4 / half replicated x2 / word.
  - If (isLoad|isStore) && !aligned: misaligned=1 next cycle; no access; no stall; stay in IDLE.
  - isLoad and isStore together: treated as load.
- REQ:
  - mem_req=1 and is held stable until mem_ready.
  - On mem_ready: mem_req drops next cycle; store goes to DONE, load goes to WAIT.
- WAIT:
  - On mem_rvalid: capture data into wbData and go to DONE.
  - Byte: mem_rdata[8*off+:8]. Half: mem_rdata[16*off[1]+:16]. Extend per loadUnsigned.
  - mem_rvalid outside WAIT is ignored; memory guarantees rvalid at least 1 cycle after acceptance.
- DONE:
  - Lasts one cycle, then returns to IDLE.
  - rdWrite=1 only if completed load and rd!=0.
  - stall=0, so the core retires the instruction at this edge.
  - isLoad/isStore are ignored in DONE; they still reflect the retiring instruction.
- stall = (IDLE && (isLoad|isStore) && aligned) || REQ || WAIT.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - At TIMEOUT: go to DONE with busError=1; rdWrite=0; mem_req dropped.
- Minimum latency: store 3 cycles (IDLE, REQ with ready, DONE); load 4 cycles (IDLE, REQ, WAIT with rvalid, DONE).
- wbData and rd hold their values until the next load completes.

Test Plan:
- Word load, addr=0x100, rdIn=5, ready on first REQ cycle, rvalid 2 cycles later with 0xDEADBEEF → stall high 4 cycles; rdWrite pulse with rd=5, wbData=0xDEADBEEF; mem_addr=0x100.
- Byte load signed/unsigned, addr=0x103, rdata=0x80FFFFFF → signed wbData=0xFFFFFF80; unsigned wbData=0x00000080.
- Half store, addr=0x102, storeData=0x1234ABCD → mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_we=1; no rdWrite; stall high 2 cycles.
- Misaligned word load at addr=0x101 → misaligned pulse 1 cycle; no mem_req; stall 0. size=3 gives the same result.
- Load with mem_ready low 3 cycles → mem_req/mem_addr stable across all REQ cycles. Load to rd=0 → no rdWrite.
- TIMEOUT=4, memory never asserts rvalid → busError pulse after 4 REQ/WAIT cycles; rdWrite 0; back to IDLE. rst_n asserted mid-WAIT → mem_req/stall 0 immediately; IDLE after release.
